// File: rtl/pc_redirect_unit.sv
// Fetch PC generator with EX-stage branch/jump redirect, misaligned-target trap
// and a fixed two-cycle IF/ID flush window after every taken control transfer.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch,
  input  logic        jump,
  input  logic [1:0]  immsel,
  input  logic [2:0]  func3,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  input  logic        stall,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  output logic        flush,
  output logic        redirect,
  output logic        misalign_err
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t      state;
  logic        fcnt;
  logic        cond;
  logic        accept;
  logic        take;
  logic [31:0] target;
  logic [31:0] pc_inc;

  always_comb begin
    cond = 1'b0;
    case (func3)
      3'b000:  cond = (rs1_data == rs2_data);
      3'b001:  cond = (rs1_data != rs2_data);
      3'b100:  cond = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101:  cond = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  cond = (rs1_data <  rs2_data);
      3'b111:  cond = (rs1_data >= rs2_data);
      default: cond = 1'b0;
    endcase
  end

  // Inconsistent decode (both flags, or immsel disagreeing with the flag) falls through as sequential.
  assign accept    = ex_valid & (state == RUN);
  assign take      = accept & ((jump & ~branch & (immsel == 2'b11)) |
                               (branch & ~jump & cond & (immsel == 2'b10)));
  assign target    = ex_pc + imm;
  assign pc_inc    = pc + 32'd4;
  assign link_addr = ex_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      state        <= RUN;
      fcnt         <= 1'b0;
      flush        <= 1'b0;
      redirect     <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      redirect     <= 1'b0;
      misalign_err <= 1'b0;
      case (state)
        RUN: begin
          // A take overrides stall so the redirect is never lost.
          if (take) begin
            flush <= 1'b1;
            state <= FLUSH;
            fcnt  <= 1'b1;
            if (target[1:0] == 2'b00) begin
              pc       <= target;
              redirect <= 1'b1;
            end else begin
              pc           <= TRAP_VEC;
              misalign_err <= 1'b1;
            end
          end else begin
            flush <= 1'b0;
            if (!stall) pc <= pc_inc;
          end
        end
        FLUSH: begin
          if (!stall) pc <= pc_inc;
          if (fcnt) begin
            fcnt <= 1'b0;
          end else begin
            state <= RUN;
            flush <= 1'b0;
          end
        end
        default: begin
          state <= RUN;
          flush <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit: each task resets, drives a scenario and
// compares {pc, flush, redirect, misalign_err} one cycle at a time.
module tb_pc_redirect_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        branch, jump, stall, ex_valid;
  logic [1:0]  immsel;
  logic [2:0]  func3;
  logic [31:0] ex_pc, rs1_data, rs2_data, imm;
  logic [31:0] pc, link_addr;
  logic        flush, redirect, misalign_err;

  int nvec = 0;
  int nmis = 0;

  pc_redirect_unit dut (
    .clk(clk), .rst_n(rst_n), .branch(branch), .jump(jump), .immsel(immsel),
    .func3(func3), .ex_valid(ex_valid), .ex_pc(ex_pc), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .imm(imm), .stall(stall), .pc(pc), .link_addr(link_addr),
    .flush(flush), .redirect(redirect), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  logic [34:0] obs;
  assign obs = {pc, flush, redirect, misalign_err};

  task automatic idle();
    branch = 0; jump = 0; immsel = 2'b00; func3 = 3'b000; ex_valid = 0; stall = 0;
    ex_pc = 0; rs1_data = 0; rs2_data = 0; imm = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic drive(input logic b, input logic j, input logic [1:0] is, input logic [2:0] f3,
                       input logic [31:0] epc, input logic [31:0] im,
                       input logic [31:0] a, input logic [31:0] c);
    branch = b; jump = j; immsel = is; func3 = f3; ex_valid = 1;
    ex_pc = epc; imm = im; rs1_data = a; rs2_data = c;
  endtask

  task automatic test_reset();
    logic [34:0] exp;
    idle();
    rst_n = 0;
    @(posedge clk); #1;
    nvec++;
    if (obs !== 35'h0) begin
      nmis++; $display("FAIL reset got %h want %h", obs, 35'h0);
    end
    rst_n = 1;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      exp = {32'(i * 4), 3'b000};
      nvec++;
      if (obs !== exp) begin
        nmis++; $display("FAIL seq_pc%0d got %h want %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_branch_eq();
    do_reset();
    drive(1, 0, 2'b10, 3'b000, 32'h40, 32'h20, 32'd5, 32'd5);
    #1;
    nvec++;
    if (link_addr !== 32'h44) begin
      nmis++; $display("FAIL beq_link got %h want %h", link_addr, 32'h44);
    end
    @(posedge clk); #1;
    nvec++;
    if (obs !== {32'h60, 3'b110}) begin
      nmis++; $display("FAIL beq_n1 got %h want %h", obs, {32'h60, 3'b110});
    end
    ex_valid = 0;
    @(posedge clk); #1;
    nvec++;
    if (obs !== {32'h64, 3'b100}) begin
      nmis++; $display("FAIL beq_n2 got %h want %h", obs, {32'h64, 3'b100});
    end
    @(posedge clk); #1;
    nvec++;
    if (obs !== {32'h68, 3'b000}) begin
      nmis++; $display("FAIL beq_n3 got %h want %h", obs, {32'h68, 3'b000});
    end
  endtask

  task automatic test_signed_unsigned();
    do_reset();
    drive(1, 0, 2'b10, 3'b100, 32'h80, 32'h10, 32'hFFFF_FFFF, 32'd1);
    @(posedge clk); #1;
    nvec++;
    if (obs !== {32'h90, 3'b110}) begin
      nmis++; $display("FAIL blt_taken got %h want %h", obs, {32'h90, 3'b110});
    end
    ex_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if (obs !== {32'h98, 3'b000}) begin
      nmis++; $display("FAIL blt_drain got %h want %h", obs, {32'h98, 3'b000});
    end
    drive(1, 0, 2'b10, 3'b110, 32'h80, 32'h10, 32'hFFFF_FFFF, 32'd1);
    @(posedge clk); #1;
    nvec++;
    if (obs !== {32'h9C, 3'b000}) begin
      nmis++; $display("FAIL bltu_nt got %h want %h", obs, {32'h9C, 3'b000});
    end
    func3 = 3'b101;
    @(posedge clk); #1;
    nvec++;
    if (obs !== {32'hA0, 3'b000}) begin
      nmis++; $display("FAIL bge_nt got %h want %h", obs, {32'hA0, 3'b000});
    end
    func3 = 3'b111;
    @(posedge clk); #1;
    nvec++;
    if (obs !== {32'h90, 3'b110}) begin
      nmis++; $display("FAIL bgeu_taken got %h want %h", obs, {32'h90, 3'b110});
    end
  endtask

  task automatic test_misalign();
    do_reset();
    drive(0, 1, 2'b11, 3'b000, 32'h10, 32'h6, 32'd0, 32'd0);
    #1;
    nvec++;
    if (link_addr !== 32'h14) begin
      nmis++; $display("FAIL jal_link got %h want %h", link_addr, 32'h14);
    end
    @(posedge clk); #1;
    nvec++;
    if (obs !== {32'h100, 3'b101}) begin
      nmis++; $display("FAIL mis_trap got %h want %h", obs, {32'h100, 3'b101});
    end
    ex_valid = 0;
    @(posedge clk); #1;
    nvec++;
    if (obs !== {32'h104, 3'b100}) begin
      nmis++; $display("FAIL mis_n2 got %h want %h", obs, {32'h104, 3'b100});
    end
    @(posedge clk); #1;
    nvec++;
    if (obs !== {32'h108, 3'b000}) begin
      nmis++; $display("FAIL mis_n3 got %h want %h", obs, {32'h108, 3'b000});
    end
  endtask

  task automatic test_stall_take();
    do_reset();
    drive(1, 0, 2'b10, 3'b001, 32'h200, 32'h8, 32'd1, 32'd2);
    stall = 1;
    @(posedge clk); #1;
    nvec++;
    if (obs !== {32'h208, 3'b110}) begin
      nmis++; $display("FAIL stall_take got %h want %h", obs, {32'h208, 3'b110});
    end
    drive(0, 1, 2'b11, 3'b000, 32'h300, 32'h40, 32'd0, 32'd0);
    @(posedge clk); #1;
    nvec++;
    if (obs !== {32'h208, 3'b100}) begin
      nmis++; $display("FAIL flush_ignore got %h want %h", obs, {32'h208, 3'b100});
    end
    stall = 0;
    @(posedge clk); #1;
    nvec++;
    if (obs !== {32'h20C, 3'b000}) begin
      nmis++; $display("FAIL flush_end got %h want %h", obs, {32'h20C, 3'b000});
    end
    idle();
  endtask

  task automatic test_inconsistent();
    do_reset();
    drive(1, 1, 2'b10, 3'b000, 32'h40, 32'h20, 32'd5, 32'd5);
    @(posedge clk); #1;
    nvec++;
    if (obs !== {32'h4, 3'b000}) begin
      nmis++; $display("FAIL both_flags got %h want %h", obs, {32'h4, 3'b000});
    end
    drive(1, 0, 2'b11, 3'b000, 32'h40, 32'h20, 32'd5, 32'd5);
    @(posedge clk); #1;
    nvec++;
    if (obs !== {32'h8, 3'b000}) begin
      nmis++; $display("FAIL br_immsel got %h want %h", obs, {32'h8, 3'b000});
    end
    drive(0, 1, 2'b10, 3'b000, 32'h40, 32'h20, 32'd5, 32'd5);
    @(posedge clk); #1;
    nvec++;
    if (obs !== {32'hC, 3'b000}) begin
      nmis++; $display("FAIL jal_immsel got %h want %h", obs, {32'hC, 3'b000});
    end
    drive(1, 0, 2'b10, 3'b010, 32'h40, 32'h20, 32'd5, 32'd5);
    @(posedge clk); #1;
    nvec++;
    if (obs !== {32'h10, 3'b000}) begin
      nmis++; $display("FAIL f3_010 got %h want %h", obs, {32'h10, 3'b000});
    end
    drive(0, 1, 2'b11, 3'b000, 32'h40, 32'h20, 32'd0, 32'd0);
    ex_valid = 0;
    stall = 1;
    @(posedge clk); #1;
    nvec++;
    if (obs !== {32'h10, 3'b000}) begin
      nmis++; $display("FAIL invalid_stall got %h want %h", obs, {32'h10, 3'b000});
    end
    idle();
  endtask

  task automatic test_reset_in_flush();
    do_reset();
    drive(1, 0, 2'b10, 3'b000, 32'h40, 32'h20, 32'd5, 32'd5);
    @(posedge clk); #1;
    nvec++;
    if (obs !== {32'h60, 3'b110}) begin
      nmis++; $display("FAIL rf_take got %h want %h", obs, {32'h60, 3'b110});
    end
    ex_valid = 0;
    rst_n = 0;
    @(posedge clk); #1;
    nvec++;
    if (obs !== 35'h0) begin
      nmis++; $display("FAIL rf_abort got %h want %h", obs, 35'h0);
    end
    rst_n = 1;
    @(posedge clk); #1;
    nvec++;
    if (obs !== {32'h4, 3'b000}) begin
      nmis++; $display("FAIL rf_release got %h want %h", obs, {32'h4, 3'b000});
    end
    drive(0, 1, 2'b11, 3'b000, 32'h40, 32'h20, 32'd0, 32'd0);
    rst_n = 0;
    @(posedge clk); #1;
    nvec++;
    if (obs !== 35'h0) begin
      nmis++; $display("FAIL rst_over_take got %h want %h", obs, 35'h0);
    end
    rst_n = 1;
    idle();
  endtask

  task automatic test_wrap();
    do_reset();
    drive(0, 1, 2'b11, 3'b000, 32'h0, 32'hFFFF_FFFC, 32'd0, 32'd0);
    @(posedge clk); #1;
    nvec++;
    if (obs !== {32'hFFFF_FFFC, 3'b110}) begin
      nmis++; $display("FAIL wrap_jmp got %h want %h", obs, {32'hFFFF_FFFC, 3'b110});
    end
    ex_valid = 0;
    @(posedge clk); #1;
    nvec++;
    if (obs !== {32'h0, 3'b100}) begin
      nmis++; $display("FAIL wrap_pc got %h want %h", obs, {32'h0, 3'b100});
    end
    @(posedge clk); #1;
    drive(0, 1, 2'b11, 3'b000, 32'hFFFF_FFF0, 32'h20, 32'd0, 32'd0);
    @(posedge clk); #1;
    nvec++;
    if (obs !== {32'h10, 3'b110}) begin
      nmis++; $display("FAIL tgt_wrap got %h want %h", obs, {32'h10, 3'b110});
    end
    idle();
  endtask

  initial begin
    idle();
    rst_n = 0;
    test_reset();
    test_branch_eq();
    test_signed_unsigned();
    test_misalign();
    test_stall_take();
    test_inconsistent();
    test_reset_in_flush();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/pc_redirect_unit.md
PC_REDIRECT_UNIT -- requirements
Module: pc_redirect_unit

Parameters
REQ-001 SHALL provide RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL provide TRAP_VEC, default 32'h0000_0100, meaning the PC loaded on a misaligned-target trap.

Interface
REQ-003 SHALL have clk  input  1  system clock; the only clock, all state on its rising edge.
REQ-004 SHALL have rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have branch  input  1  from decode; conditional branch in EX.
REQ-006 SHALL have jump  input  1  from decode; JAL in EX.
REQ-007 SHALL have immsel  input  2  from decode; 2'b10 B-type, 2'b11 J-type; used only for the consistency check (REQ-020).
REQ-008 SHALL have func3  input  3  branch condition select.
REQ-009 SHALL have ex_valid  input  1  EX holds a real instruction.
REQ-010 SHALL have ex_pc, rs1_data, rs2_data, imm  input  32 each  EX instruction PC, operands, sign-extended immediate.
REQ-011 SHALL have stall  input  1  hold fetch PC.
REQ-012 SHALL have pc  output  32  fetch PC, registered.
REQ-013 SHALL have link_addr  output  32  ex_pc+4, combinational.
REQ-014 SHALL have flush  output  1  squash IF/ID, registered.
REQ-015 SHALL have redirect  output  1  one-cycle pulse, PC was redirected.
REQ-016 SHALL have misalign_err  output  1  one-cycle pulse, target misaligned, trapped.

Function
REQ-017 SHALL evaluate the condition by func3: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge; 010/011 are never taken.
REQ-018 SHALL compute target = ex_pc + imm, modulo 2^32, with no overflow flag.
REQ-019 SHALL define accept = ex_valid & state==RUN; take = accept & (jump | (branch & cond)).
REQ-020 SHALL treat branch&jump both high, or take with immsel not matching (10 for branch, 11 for jump), as not taken and SHALL increment PC normally.
REQ-021 SHALL have two states: RUN and FLUSH, with a 1-bit counter fcnt.
REQ-022 RUN, take, target[1:0]==0: next pc=target, redirect=1, flush=1, state FLUSH, fcnt=1.
REQ-023 RUN, take, target[1:0]!=0: next pc=TRAP_VEC, misalign_err=1, flush=1, state FLUSH, fcnt=1, redirect=0.
REQ-024 RUN, no take: pc holds if stall, else pc+4; flush=0.
REQ-025 FLUSH: ex_valid ignored; flush stays 1; pc advances by 4 unless stall; fcnt==1 -> fcnt=0; fcnt==0 -> RUN, flush=0.
REQ-026 SHALL give flush high for exactly two cycles (N+1, N+2) after a take in cycle N, independent of stall.
REQ-027 take and stall in the same cycle: take SHALL win, and stall SHALL NOT block the redirect.
REQ-028 redirect and misalign_err SHALL be high only in cycle N+1 and SHALL never both be high.
REQ-029 pc wrap from 32'hFFFF_FFFC SHALL give 0.

Reset
REQ-030 rst_n low at a clk edge SHALL set pc=RESET_PC, state RUN, fcnt=0, flush=0, redirect=0, misalign_err=0, overriding any take in that cycle.
REQ-031 Reset asserted during FLUSH SHALL abort it; first cycle after release is RUN with flush=0.

Verification
REQ-032 Reset, then 3 cycles with no stall -> pc 0, 4, 8, C.
REQ-033 ex_pc=0x40, imm=0x20, branch, func3=000, rs1=rs2=5 -> next cycle pc=0x60, redirect=1; flush=1 for 2 cycles; pc=0x64, 0x68.
REQ-034 func3=100, rs1=0xFFFF_FFFF, rs2=1 -> taken; func3=110, same operands -> not taken; pc+4.
REQ-035 jump, ex_pc=0x10, imm=0x6 -> pc=0x100, misalign_err=1, redirect=0, link_addr=0x14.
REQ-036 take with stall=1 -> redirect still occurs; a second take during FLUSH is ignored.
REQ-037 rst_n low in the cycle after a redirect -> pc=RESET_PC, flush=0 next cycle.
